// File: rtl/bcd_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_ctrl
// Brief    : Binary-to-BCD converter (sequential shift-add-3, one bit per
//            clock) feeding a free-running multiplexed 7-segment scanner.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_BCD_W = 4 * DIGITS;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // The largest binary input must fit in DIGITS decimal digits.
    if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_bad_digits
        $error("bcd_display_ctrl: DIGITS too small for WIDTH");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("bcd_display_ctrl: REFRESH_DIV must be >= 2");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [c_BCD_W-1:0] r_scratch;
    logic [c_BCD_W-1:0] w_adj;
    logic [c_CNT_W-1:0] r_count;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_REF_W-1:0] r_refresh;
    logic [c_IDX_W-1:0] r_idx;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;
    logic [6:0]         r_seg;
    logic [DIGITS-1:0]  w_an;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: accept in IDLE, leave SHIFT after the last bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bin_valid) w_state_next = c_ST_SHIFT;
            c_ST_SHIFT: if (r_count == c_CNT_W'(1)) w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Add-3 correction on every nibble, all taken from the pre-shift value.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath; bcd_out only changes when a conversion completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bin_valid) begin
                        r_shift   <= bin_in;
                        r_scratch <= '0;
                        r_count   <= c_CNT_W'(WIDTH);
                    end
                end
                c_ST_SHIFT: begin
                    r_scratch <= {w_adj[c_BCD_W-2:0], r_shift[WIDTH-1]};
                    r_shift   <= r_shift << 1;
                    r_count   <= r_count - c_CNT_W'(1);
                end
                c_ST_DONE: r_bcd <= r_scratch;
                default: ;
            endcase
        end
    end

    // Scan counter and digit index, free-running regardless of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_seg     <= 7'b0000001;
        end else begin
            r_seg <= w_seg;
            if (r_refresh == c_REF_W'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_refresh <= r_refresh + c_REF_W'(1);
            end
        end
    end

    // Select the nibble and anode for the digit currently being scanned.
    always_comb begin
        w_nib = '0;
        w_an  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib   = r_bcd[4*i +: 4];
                w_an[i] = 1'b0;
            end
        end
    end

    // Active-low 7-segment decode {a..g}; non-decimal nibbles are blanked.
    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'd0: w_seg = 7'b0000001;
            4'd1: w_seg = 7'b1001111;
            4'd2: w_seg = 7'b0010010;
            4'd3: w_seg = 7'b0000110;
            4'd4: w_seg = 7'b1001100;
            4'd5: w_seg = 7'b0100100;
            4'd6: w_seg = 7'b0100000;
            4'd7: w_seg = 7'b0001111;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0000100;
            default: w_seg = 7'b1111111;
        endcase
    end

    assign bin_ready = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);
    assign bcd_valid = (r_state == c_ST_DONE);
    assign bcd_out   = r_bcd;
    assign seg       = r_seg;
    assign an        = w_an;

endmodule
`default_nettype wire
